fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Run controller that sequences the fetch stage through a fixed list of N programs held in instruction memory. For each program it loads the start address into the PC, lets fetch run until the core signals halt or a cycle budget expires, drains the pipeline, and records the run length. It sits between the testbench/top-level start control and the fetch stage's reset/halt/reset-address inputs.

Parameters:
A, 10, instruction address width (matches fetch stage)
N, 3, number of programs in the sequence (1..8)
START_ADDRS, {10'd0,10'd0,10'd0}, packed N*A start-address table; entry i at bits [i*A +: A]
CW, 16, cycle counter width
MAX_CYC, 16'hFFFF, per-program cycle budget (RUN cycles, >=1)
DRAIN_CYC, 3, pipeline drain cycles after halt (>=1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
start  input  1  one-cycle request to start the sequence; honoured only in IDLE or DONE
halt_req  input  1  core has decoded a halt instruction; sampled only in RUN
if_reset  output  1  drives fetch-stage reset: PC loads if_addr
if_halt  output  1  drives fetch-stage halt: PC holds
if_addr  output  A  start address for the fetch stage, START_ADDRS[prog_idx]
prog_idx  output  3  index of the current/last program
prog_done  output  1  one-cycle pulse at end of each program's DRAIN
timeout  output  1  valid with prog_done: program hit MAX_CYC without halt_req
last_cycles  output  CW  RUN-cycle count of most recently completed program
seq_done  output  1  high in DONE state

Behaviour:
- States: IDLE, LOAD, RUN, DRAIN, DONE. Moore outputs decoded from registered state only; no combinational input-to-output path.
- Async reset: state=IDLE, prog_idx=0, cycle count=0, drain count=0, last_cycles=0, timeout=0, prog_done=0. Hence if_halt=1, if_reset=0, if_addr=START_ADDRS[0], seq_done=0.
- IDLE: if_halt=1. start -> LOAD, prog_idx<=0.
- LOAD (exactly 1 cycle): if_reset=1, if_halt=0, if_addr=START_ADDRS[prog_idx]; cycle count<=0 -> RUN. First fetch at start address occurs on the clock edge ending LOAD.
- RUN: if_reset=0, if_halt=0, so PC advances or branches normally. Each cycle: if halt_req, then last_cycles<=count+1, timeout<=0, go to DRAIN. Elif count==MAX_CYC-1, then last_cycles<=MAX_CYC, timeout<=1, go to DRAIN. Else count<=count+1.
- halt_req on the same cycle the budget expires: halt_req wins, timeout=0.
- DRAIN: if_halt=1 for exactly DRAIN_CYC cycles. In the final cycle prog_done=1 (registered pulse, one cycle). Then: if prog_idx==N-1, go to DONE; else prog_idx<=prog_idx+1 and go to LOAD.
- DONE: if_halt=1, seq_done=1, prog_idx holds N-1, last_cycles/timeout hold. start -> LOAD with prog_idx=0, restarting the sequence.
- start is ignored in LOAD, RUN and DRAIN. halt_req is ignored outside RUN.
- if_reset and if_halt are never both 1.
- prog_done and timeout: timeout is held until the next program's completion. prog_done is high only for 1 cycle.
- Reset asserted mid-run (any state): immediate return to IDLE values, with no prog_done pulse.
- Counter never wraps: the MAX_CYC bound guarantees count < 2^CW.

Test Plan:
- Reset release, then start pulse with N=3, START_ADDRS={300,100,0}, halt_req at RUN cycle 5 of each program -> if_reset high 1 cycle with if_addr=0, 100, 300 in turn; last_cycles=5 at each prog_done; seq_done after the third DRAIN; prog_idx=2.
- MAX_CYC=8, halt_req never asserted -> DRAIN entered after 8 RUN cycles; prog_done with timeout=1, last_cycles=8.
- halt_req asserted on RUN cycle 8 with MAX_CYC=8 -> timeout=0, last_cycles=8.
- start pulsed during RUN and DRAIN -> no effect; start pulsed in DONE -> LOAD with if_addr=START_ADDRS[0], prog_idx=0.
- Async reset asserted mid-RUN of program 1 (between clock edges) -> outputs immediately at IDLE values (if_halt=1, prog_idx=0, last_cycles=0); no prog_done pulse.
- DRAIN_CYC=3, halt_req in RUN cycle 1 -> if_halt high exactly 3 cycles; prog_done coincides with the 3rd; the next LOAD follows on the next cycle.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: control bus between the run sequencer and the fetch stage
interface fetch_sequencer_if #(
    parameter int A = 10
) ();
    logic         if_reset;
    logic         if_halt;
    logic [A-1:0] if_addr;
    logic         halt_req;
    modport master (output if_reset, if_halt, if_addr, input halt_req);
    modport slave  (input if_reset, if_halt, if_addr, output halt_req);
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: runs the fetch stage through N programs, timing each run and draining between them
module fetch_sequencer #(
    parameter int             A           = 10,
    parameter int             N           = 3,
    parameter logic [N*A-1:0] START_ADDRS = '0,
    parameter int             CW          = 16,
    parameter logic [CW-1:0]  MAX_CYC     = 16'hFFFF,
    parameter int             DRAIN_CYC   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    fetch_sequencer_if.master   fif,
    output logic [2:0]          prog_idx,
    output logic                prog_done,
    output logic                timeout,
    output logic [CW-1:0]       last_cycles,
    output logic                seq_done
);
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, DRAIN = 3'd3, DONE = 3'd4;
    localparam int DW = $clog2(DRAIN_CYC + 1);
    localparam logic [DW-1:0] DLAST = DW'(DRAIN_CYC - 1);
    localparam logic [CW-1:0] CLAST = MAX_CYC - 1'b1;
    localparam logic [2:0] NLAST = 3'(N - 1);
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dcnt;
    assign fif.if_reset = state == LOAD;
    assign fif.if_halt  = state == IDLE || state == DRAIN || state == DONE;
    assign fif.if_addr  = START_ADDRS[int'(prog_idx)*A +: A];
    assign seq_done     = state == DONE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prog_idx    <= '0;
            cnt         <= '0;
            dcnt        <= '0;
            last_cycles <= '0;
            timeout     <= 1'b0;
            prog_done   <= 1'b0;
        end else begin
            prog_done <= 1'b0;
            case (state)
                IDLE, DONE: if (start) begin
                    state    <= LOAD;
                    prog_idx <= '0;
                end
                LOAD: begin
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: if (fif.halt_req || cnt == CLAST) begin
                    // halt_req takes priority over a budget expiring on the same cycle
                    last_cycles <= fif.halt_req ? cnt + 1'b1 : MAX_CYC;
                    timeout     <= !fif.halt_req;
                    dcnt        <= '0;
                    prog_done   <= DRAIN_CYC == 1;
                    state       <= DRAIN;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DRAIN: if (dcnt == DLAST) begin
                    state    <= prog_idx == NLAST ? DONE : LOAD;
                    prog_idx <= prog_idx == NLAST ? prog_idx : prog_idx + 3'd1;
                end else begin
                    dcnt      <= dcnt + 1'b1;
                    prog_done <= dcnt + 1'b1 == DLAST;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven and randomized check of fetch_sequencer against a timeline model
module tb_fetch_sequencer;
    localparam int A = 10, N = 3, CW = 16, D = 3, MAXC = 8;
    localparam logic [N*A-1:0] SA = {10'd300, 10'd100, 10'd0};
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [2:0] prog_idx;
    logic prog_done, timeout, seq_done;
    logic [CW-1:0] last_cycles;
    fetch_sequencer_if #(.A(A)) bus ();
    fetch_sequencer #(
        .A(A), .N(N), .START_ADDRS(SA), .CW(CW), .MAX_CYC(16'(MAXC)), .DRAIN_CYC(D)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .fif(bus.master),
        .prog_idx(prog_idx), .prog_done(prog_done), .timeout(timeout),
        .last_cycles(last_cycles), .seq_done(seq_done)
    );
    always #5 clk = ~clk;
    // kind: 0 idle, 1 load, 2 run, 3 drain, 4 done; c is the 1-based RUN cycle
    typedef struct {int kind; int idx; int c; int last; bit to; bit pd;} slot_t;
    typedef struct {logic [2:0][15:0] h; logic [2:0][15:0] last; logic [2:0] to;} row_t;
    int addr_tab[3] = '{0, 100, 300};
    slot_t q[$];
    slot_t cur, idle_s;
    row_t tab[6];
    int checks = 0, errs = 0;
    function automatic logic [33:0] exp_vec(slot_t s);
        return {s.kind == 1, s.kind != 1 && s.kind != 2, 10'(addr_tab[s.idx]), 3'(s.idx),
                s.pd, s.to, 16'(s.last), s.kind == 4};
    endfunction
    task automatic check(string nm, slot_t s);
        logic [33:0] act;
        act = {bus.if_reset, bus.if_halt, bus.if_addr, prog_idx, prog_done, timeout, last_cycles, seq_done};
        checks++;
        if (act !== exp_vec(s)) begin
            errs++;
            $display("FAIL %s t=%0t kind=%0d idx=%0d c=%0d got %h want %h", nm, $time, s.kind, s.idx, s.c, act, exp_vec(s));
        end
    endtask
    task automatic build(row_t r);
        int lst;
        bit to;
        lst = cur.last;
        to = cur.to;
        q.delete();
        for (int i = 0; i < N; i++) begin
            q.push_back('{1, i, 0, lst, to, 1'b0});
            for (int c = 1; c <= int'(r.last[i]); c++) q.push_back('{2, i, c, lst, to, 1'b0});
            lst = int'(r.last[i]);
            to = r.to[i];
            for (int d = 1; d <= D; d++) q.push_back('{3, i, 0, lst, to, d == D});
        end
        q.push_back('{4, N - 1, 0, lst, to, 1'b0});
        q.push_back('{4, N - 1, 0, lst, to, 1'b0});
    endtask
    task automatic drive(slot_t s, row_t r);
        start = (s.kind >= 1 && s.kind <= 3) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.halt_req = s.kind == 2 ? (s.c == int'(r.h[s.idx])) : 1'($urandom_range(0, 1));
    endtask
    task automatic begin_row(row_t r);
        build(r);
        @(negedge clk);
        check("pre", cur);
        start = 1'b1;
        bus.halt_req = 1'($urandom_range(0, 1));
    endtask
    task automatic run_row(row_t r);
        begin_row(r);
        foreach (q[k]) begin
            @(negedge clk);
            check("seq", q[k]);
            drive(q[k], r);
        end
        cur = q[$];
    endtask
    function automatic row_t rand_row();
        row_t r;
        for (int i = 0; i < N; i++) begin
            r.h[i] = 16'($urandom_range(0, 10));
            r.last[i] = (r.h[i] >= 1 && r.h[i] <= MAXC) ? r.h[i] : 16'(MAXC);
            r.to[i] = !(r.h[i] >= 1 && r.h[i] <= MAXC);
        end
        return r;
    endfunction
    initial begin
        tab[0] = '{h: {16'd5, 16'd5, 16'd5}, last: {16'd5, 16'd5, 16'd5}, to: 3'b000};
        tab[1] = '{h: {16'd0, 16'd0, 16'd0}, last: {16'd8, 16'd8, 16'd8}, to: 3'b111};
        tab[2] = '{h: {16'd8, 16'd8, 16'd8}, last: {16'd8, 16'd8, 16'd8}, to: 3'b000};
        tab[3] = '{h: {16'd1, 16'd1, 16'd1}, last: {16'd1, 16'd1, 16'd1}, to: 3'b000};
        tab[4] = '{h: {16'd3, 16'd0, 16'd8}, last: {16'd3, 16'd8, 16'd8}, to: 3'b010};
        tab[5] = '{h: {16'd9, 16'd2, 16'd7}, last: {16'd8, 16'd2, 16'd7}, to: 3'b100};
        idle_s = '{0, 0, 0, 0, 1'b0, 1'b0};
        cur = idle_s;
        bus.halt_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("reset", idle_s);
        end
        reset = 1'b0;
        foreach (tab[t]) run_row(tab[t]);
        // asynchronous reset in the middle of program 1's RUN
        begin_row(tab[0]);
        foreach (q[k]) begin
            @(negedge clk);
            check("seq", q[k]);
            drive(q[k], tab[0]);
            if (q[k].kind == 2 && q[k].idx == 1 && q[k].c == 2) break;
        end
        #2 reset = 1'b1;
        #1 check("async_reset", idle_s);
        start = 1'b0;
        @(negedge clk);
        check("in_reset", idle_s);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_reset", idle_s);
            bus.halt_req = 1'($urandom_range(0, 1));
        end
        cur = idle_s;
        repeat (20) run_row(rand_row());
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule
